// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with per-register pending-write scoreboard
//
// Purpose: NUM_READ combinational read ports, one synchronous write port with
// optional same-cycle forwarding, and a pending-write counter per register so
// decode can detect RAW hazards directly from rd_busy.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   rd_addr/rd_data   packed read ports (port k at [k*AW +: AW] / [k*WORD_LEN +: WORD_LEN])
//   rd_busy           per read port: register has an unresolved pending write
//   wr_en, sclr       write enable; sclr writes zero and overrides wr_en
//   wr_addr, wr_data  write address and data
//   rsv_en, rsv_addr  reserve a destination register
//   rsv_ready         rsv_addr can take a reservation this cycle
//   flush             clear every pending counter
//   any_pending       some counter is nonzero
//   err               sticky protocol-error flag, cleared only by rst

module regfile_scoreboard #(
  parameter int WORD_LEN     = 32,
  parameter int WORD_COUNT   = 15,
  parameter int NUM_READ     = 3,
  parameter int MAX_INFLIGHT = 2,
  parameter int BYPASS       = 1,
  parameter int RESET_INDEX  = 1,
  localparam int AW = $clog2(WORD_COUNT),
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ*AW-1:0]       rd_addr,
  output logic [NUM_READ*WORD_LEN-1:0] rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         wr_en,
  input  logic                         sclr,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WORD_LEN-1:0]          wr_data,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  output logic                         rsv_ready,
  input  logic                         flush,
  output logic                         any_pending,
  output logic                         err
);

  localparam logic [AW:0]   COUNT_LIMIT = (AW+1)'(WORD_COUNT);
  localparam logic [CW-1:0] CNT_MAX     = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  logic [WORD_LEN-1:0] regs [0:WORD_COUNT-1];
  logic [CW-1:0]       cnt  [0:WORD_COUNT-1];

  logic                wrEff;
  logic                wrInRange;
  logic                wrValid;
  logic [WORD_LEN-1:0] wrVal;
  logic [AW-1:0]       wrIdx;
  logic                rsvInRange;
  logic [AW-1:0]       rsvIdx;
  logic                rsvOk;
  logic                errSet;

  assign wrEff      = sclr | wr_en;
  assign wrVal      = sclr ? '0 : wr_data;
  assign wrInRange  = {1'b0, wr_addr} < COUNT_LIMIT;
  assign wrValid    = wrEff && wrInRange;
  // Out-of-range addresses are steered to entry 0 so array reads stay in bounds;
  // the in-range flag masks the result.
  assign wrIdx      = wrInRange ? wr_addr : '0;

  assign rsvInRange = {1'b0, rsv_addr} < COUNT_LIMIT;
  assign rsvIdx     = rsvInRange ? rsv_addr : '0;

  // A full counter can still take a reservation when a writeback to the same
  // register retires one entry in this cycle.
  assign rsv_ready  = rsvInRange &&
                      ((cnt[rsvIdx] < CNT_MAX) ||
                       ((cnt[rsvIdx] == CNT_MAX) && wrValid && (wr_addr == rsv_addr)));
  assign rsvOk      = rsv_en && rsv_ready;

  assign errSet = (rsv_en && !rsv_ready) ||
                  (wrEff && !wrInRange) ||
                  (wrValid && (cnt[wrIdx] == '0) && !flush);

  // Read ports
  for (genvar k = 0; k < NUM_READ; k++) begin : gRead
    logic [AW-1:0] addr;
    logic [AW-1:0] idx;
    logic          inRange;
    logic          hit;

    assign addr    = rd_addr[k*AW +: AW];
    assign inRange = {1'b0, addr} < COUNT_LIMIT;
    assign idx     = inRange ? addr : '0;
    assign hit     = (BYPASS != 0) && wrValid && (wr_addr == addr);

    assign rd_data[k*WORD_LEN +: WORD_LEN] = !inRange ? '0 :
                                             hit      ? wrVal : regs[idx];
    // A last outstanding write landing this cycle resolves the hazard early.
    assign rd_busy[k] = inRange && (cnt[idx] != '0) && !(hit && (cnt[idx] == CNT_ONE));
  end

  // Per-register storage and pending counter
  for (genvar i = 0; i < WORD_COUNT; i++) begin : gReg
    logic [WORD_LEN-1:0] regQ;
    logic [CW-1:0]       cntQ;
    logic                rsvHit;
    logic                wrHit;

    assign rsvHit = rsvOk && (rsv_addr == AW'(i));
    assign wrHit  = wrValid && (wr_addr == AW'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regQ <= (RESET_INDEX != 0) ? WORD_LEN'(i) : '0;
        cntQ <= '0;
      end else begin
        if (wrHit) begin
          regQ <= wrVal;
        end
        if (flush) begin
          cntQ <= '0;
        end else if (rsvHit && !wrHit) begin
          cntQ <= cntQ + CNT_ONE;
        end else if (wrHit && !rsvHit && (cntQ != '0)) begin
          cntQ <= cntQ - CNT_ONE;
        end
      end
    end

    assign regs[i] = regQ;
    assign cnt[i]  = cntQ;
  end

  always_comb begin
    any_pending = 1'b0;
    for (int i = 0; i < WORD_COUNT; i++) begin
      any_pending = any_pending | (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (errSet) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard

module tb_regfile_scoreboard;

  localparam int WL = 32;
  localparam int WC = 15;
  localparam int NR = 3;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR*AW-1:0] rdAddr = '0;
  logic            wrEn = 1'b0;
  logic            sclr = 1'b0;
  logic [AW-1:0]   wrAddr = '0;
  logic [WL-1:0]   wrData = '0;
  logic            rsvEn = 1'b0;
  logic [AW-1:0]   rsvAddr = '0;
  logic            flush = 1'b0;

  logic [NR*WL-1:0] rdData,  rdDataNb;
  logic [NR-1:0]    rdBusy,  rdBusyNb;
  logic             rsvReady, rsvReadyNb;
  logic             anyPending, anyPendingNb;
  logic             err, errNb;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.WORD_LEN(WL), .WORD_COUNT(WC), .NUM_READ(NR),
                       .MAX_INFLIGHT(2), .BYPASS(1), .RESET_INDEX(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
    .wr_en(wrEn), .sclr(sclr), .wr_addr(wrAddr), .wr_data(wrData),
    .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ready(rsvReady), .flush(flush),
    .any_pending(anyPending), .err(err)
  );

  regfile_scoreboard #(.WORD_LEN(WL), .WORD_COUNT(WC), .NUM_READ(NR),
                       .MAX_INFLIGHT(2), .BYPASS(0), .RESET_INDEX(1)) dutNb (
    .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataNb), .rd_busy(rdBusyNb),
    .wr_en(wrEn), .sclr(sclr), .wr_addr(wrAddr), .wr_data(wrData),
    .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ready(rsvReadyNb), .flush(flush),
    .any_pending(anyPendingNb), .err(errNb)
  );

  always #5 clk = ~clk;

  function automatic logic [WL-1:0] dataOf(input logic [NR*WL-1:0] bus, input int k);
    return bus[k*WL +: WL];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wrEn = 1'b0; sclr = 1'b0; rsvEn = 1'b0; flush = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < WC; i++) begin
      rdAddr = {AW'(i), AW'(i), AW'(i)};
      rsvAddr = AW'(i);
      #1;
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (dataOf(rdData, k) !== WL'(i)) begin
          errors++;
          $display("FAIL reset_data reg %0d port %0d got %h want %h", i, k, dataOf(rdData, k), WL'(i));
        end
      end
      checks++;
      if (rdBusy !== 3'b000 || rsvReady !== 1'b1) begin
        errors++;
        $display("FAIL reset_busy reg %0d busy %b ready %b want 000/1", i, rdBusy, rsvReady);
      end
    end
    checks++;
    if (err !== 1'b0 || anyPending !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags err %b pending %b want 0/0", err, anyPending);
    end
    rdAddr = {AW'(15), AW'(15), AW'(15)};
    rsvAddr = AW'(15);
    #1;
    checks++;
    if (dataOf(rdData, 0) !== '0 || rdBusy !== 3'b000 || rsvReady !== 1'b0) begin
      errors++;
      $display("FAIL oor_read data %h busy %b ready %b want 0/000/0", dataOf(rdData, 0), rdBusy, rsvReady);
    end
  endtask

  task automatic test_bypass_write();
    doReset();
    rdAddr = {AW'(0), AW'(0), AW'(3)};
    wrEn = 1'b1; wrAddr = AW'(3); wrData = 32'hDEADBEEF;
    #1;
    checks++;
    if (dataOf(rdData, 0) !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h want deadbeef", dataOf(rdData, 0));
    end
    checks++;
    if (dataOf(rdDataNb, 0) !== 32'd3) begin
      errors++;
      $display("FAIL nobypass_same_cycle got %h want 00000003", dataOf(rdDataNb, 0));
    end
    tick();
    wrEn = 1'b0;
    #1;
    checks++;
    if (dataOf(rdData, 0) !== 32'hDEADBEEF || dataOf(rdDataNb, 0) !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_committed got %h/%h want deadbeef", dataOf(rdData, 0), dataOf(rdDataNb, 0));
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_unreserved_write got %b want 1", err);
    end
  endtask

  task automatic test_scoreboard();
    doReset();
    rdAddr = {AW'(0), AW'(0), AW'(5)};
    rsvAddr = AW'(5);
    rsvEn = 1'b1;
    tick();
    tick();
    rsvEn = 1'b0;
    #1;
    checks++;
    if (rdBusy[0] !== 1'b1 || rsvReady !== 1'b0 || anyPending !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL sb_two_rsv busy %b ready %b pend %b err %b want 1/0/1/0", rdBusy[0], rsvReady, anyPending, err);
    end
    rsvEn = 1'b1;
    tick();
    rsvEn = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || rsvReady !== 1'b0) begin
      errors++;
      $display("FAIL sb_third_rsv err %b ready %b want 1/0", err, rsvReady);
    end
    wrEn = 1'b1; wrAddr = AW'(5); wrData = 32'h11;
    #1;
    checks++;
    if (rdBusy[0] !== 1'b1 || rsvReady !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb1_same_cycle busy %b ready %b want 1/1", rdBusy[0], rsvReady);
    end
    tick();
    wrEn = 1'b0;
    #1;
    checks++;
    if (rdBusy[0] !== 1'b1 || rsvReady !== 1'b1) begin
      errors++;
      $display("FAIL sb_after_wb1 busy %b ready %b want 1/1", rdBusy[0], rsvReady);
    end
    wrEn = 1'b1; wrData = 32'h22;
    #1;
    checks++;
    if (rdBusy[0] !== 1'b0 || dataOf(rdData, 0) !== 32'h22) begin
      errors++;
      $display("FAIL sb_wb2_bypass busy %b data %h want 0/00000022", rdBusy[0], dataOf(rdData, 0));
    end
    checks++;
    if (rdBusyNb[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb2_nobypass busy %b want 1", rdBusyNb[0]);
    end
    tick();
    wrEn = 1'b0;
    #1;
    checks++;
    if (rdBusy[0] !== 1'b0 || anyPending !== 1'b0 || dataOf(rdData, 0) !== 32'h22) begin
      errors++;
      $display("FAIL sb_done busy %b pend %b data %h want 0/0/00000022", rdBusy[0], anyPending, dataOf(rdData, 0));
    end
  endtask

  task automatic test_rsv_write_same_cycle();
    doReset();
    rdAddr = {AW'(0), AW'(0), AW'(7)};
    rsvAddr = AW'(7);
    rsvEn = 1'b1;
    tick();
    wrEn = 1'b1; wrAddr = AW'(7); wrData = 32'h77;
    tick();
    idleInputs();
    #1;
    checks++;
    if (rdBusy[0] !== 1'b1 || dataOf(rdData, 0) !== 32'h77 || err !== 1'b0) begin
      errors++;
      $display("FAIL rw_same busy %b data %h err %b want 1/00000077/0", rdBusy[0], dataOf(rdData, 0), err);
    end
    // A count of exactly one lets a lone writeback clear busy in the same cycle.
    wrEn = 1'b1; wrData = 32'h78;
    #1;
    checks++;
    if (rdBusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rw_count_one busy %b want 0", rdBusy[0]);
    end
    tick();
    wrEn = 1'b0;
    #1;
    checks++;
    if (anyPending !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rw_drained pend %b err %b want 0/0", anyPending, err);
    end
  endtask

  task automatic test_flush();
    doReset();
    rdAddr = {AW'(4), AW'(2), AW'(1)};
    rsvEn = 1'b1;
    rsvAddr = AW'(1); tick();
    rsvAddr = AW'(2); tick();
    rsvAddr = AW'(4); tick();
    rsvEn = 1'b0;
    #1;
    checks++;
    if (rdBusy !== 3'b111 || anyPending !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre busy %b pend %b want 111/1", rdBusy, anyPending);
    end
    flush = 1'b1; rsvEn = 1'b1; rsvAddr = AW'(6);
    tick();
    idleInputs();
    rdAddr = {AW'(6), AW'(2), AW'(1)};
    #1;
    checks++;
    if (rdBusy !== 3'b000 || anyPending !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL flush_post busy %b pend %b err %b want 000/0/0", rdBusy, anyPending, err);
    end
    wrEn = 1'b1; wrAddr = AW'(1); wrData = 32'hA1;
    tick();
    wrEn = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || dataOf(rdData, 0) !== 32'hA1) begin
      errors++;
      $display("FAIL flush_late_write err %b data %h want 1/000000a1", err, dataOf(rdData, 0));
    end
  endtask

  task automatic test_sclr_async_reset();
    doReset();
    rdAddr = {AW'(0), AW'(0), AW'(9)};
    sclr = 1'b1; wrEn = 1'b1; wrAddr = AW'(9); wrData = 32'h55;
    #1;
    checks++;
    if (dataOf(rdData, 0) !== '0) begin
      errors++;
      $display("FAIL sclr_bypass got %h want 0", dataOf(rdData, 0));
    end
    tick();
    idleInputs();
    #1;
    checks++;
    if (dataOf(rdData, 0) !== '0 || err !== 1'b1) begin
      errors++;
      $display("FAIL sclr_commit data %h err %b want 0/1", dataOf(rdData, 0), err);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dataOf(rdData, 0) !== 32'd9 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset data %h err %b want 00000009/0", dataOf(rdData, 0), err);
    end
    wrEn = 1'b1; wrData = 32'hAA; rsvEn = 1'b1; rsvAddr = AW'(9);
    tick();
    idleInputs();
    #1;
    checks++;
    if (dataOf(rdData, 0) !== 32'd9 || anyPending !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores data %h pend %b err %b want 00000009/0/0", dataOf(rdData, 0), anyPending, err);
    end
    rst = 1'b0;
    #1;
    wrEn = 1'b1; wrAddr = AW'(15); wrData = 32'hBB;
    tick();
    wrEn = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || dataOf(rdData, 0) !== 32'd9) begin
      errors++;
      $display("FAIL oor_write err %b data %h want 1/00000009", err, dataOf(rdData, 0));
    end
  endtask

  initial begin
    test_reset();
    test_bypass_write();
    test_scoreboard();
    test_rsv_write_same_cycle();
    test_flush();
    test_sclr_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
